// File: rtl/se_pkg.sv
// Shared defaults and FSM encoding for the sigmoid write-back scheduler.
package se_pkg;

  localparam int SE_DATA_WIDTH = 14;
  localparam int SE_FRAC_BITS  = 9;
  localparam int SE_IN_WIDTH   = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } se_state_e;

endpackage

// File: rtl/se_sigmoid_sched_if.sv
// Job control, pre-activation read, hard-sigmoid and scale-buffer write signals.
interface se_sigmoid_sched_if
  import se_pkg::*;
#(
  parameter int DATA_WIDTH = SE_DATA_WIDTH,
  parameter int IN_WIDTH   = SE_IN_WIDTH,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH:0]   num_ch;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IN_WIDTH-1:0]   rd_data;
  logic                  hs_en;
  logic [IN_WIDTH-1:0]   hs_data;
  logic                  hs_valid;
  logic [DATA_WIDTH-1:0] hs_out;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // slave is the scheduler's view, master the surrounding datapath's
  modport slave (
    input  start, num_ch, rd_data, hs_valid, hs_out, wr_ready,
    output busy, done, rd_en, rd_addr, hs_en, hs_data, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, num_ch, rd_data, hs_valid, hs_out, wr_ready,
    input  busy, done, rd_en, rd_addr, hs_en, hs_data, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/se_skid_fifo.sv
// Synchronous FIFO with count output; simultaneous push/pop is legal at full and empty.
module se_skid_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || pop_i);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/se_sigmoid_sched.sv
// Streams num_ch pre-activations through an external hard-sigmoid unit into the
// scale buffer in channel order, using credits so the skid FIFO never overflows.
module se_sigmoid_sched
  import se_pkg::*;
#(
  parameter int DATA_WIDTH = SE_DATA_WIDTH,
  parameter int FRAC_BITS  = SE_FRAC_BITS,
  parameter int IN_WIDTH   = SE_IN_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int HS_LAT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  se_sigmoid_sched_if.slave bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = FC_W + 1;

  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < HS_LAT + 2) ||
      (FRAC_BITS >= DATA_WIDTH)) begin : g_param_check
    $error("se_sigmoid_sched: FIFO_DEPTH must be a power of 2 >= HS_LAT+2, FRAC_BITS < DATA_WIDTH");
  end

  se_state_e             state_q;
  logic [CNT_W-1:0]      num_ch_q;
  logic [CNT_W-1:0]      issue_cnt_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic [CW-1:0]         inflight_q;
  logic [CW-1:0]         inflight_d;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  hs_en_q;
  logic                  done_q;

  logic                  hs_accept;
  logic                  wr_fire;
  logic                  last_wr;
  logic                  credit_ok;
  logic [FC_W-1:0]       fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  // A result arriving with nothing outstanding belongs to an abandoned job.
  assign hs_accept = bus.hs_valid && (inflight_q != '0);
  assign wr_fire   = !fifo_empty && bus.wr_ready;
  assign last_wr   = wr_fire && (wr_cnt_q == num_ch_q - 1'b1);

  // The read on the bus this cycle already holds a slot, so count it too.
  assign credit_ok = (inflight_q + {1'b0, fifo_count} + CW'(rd_en_q)) < CW'(FIFO_DEPTH);

  always_comb begin
    inflight_d = inflight_q;
    if (rd_en_q && !hs_accept)      inflight_d = inflight_q + 1'b1;
    else if (!rd_en_q && hs_accept) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_ch_q    <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      inflight_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      hs_en_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      hs_en_q    <= rd_en_q;
      inflight_q <= inflight_d;
      if (wr_fire) wr_cnt_q <= wr_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.num_ch == '0) begin
              done_q <= 1'b1;
            end else begin
              // Channel 0 is issued on the accepting edge to save a cycle.
              state_q     <= ST_RUN;
              num_ch_q    <= bus.num_ch;
              issue_cnt_q <= CNT_W'(1);
              wr_cnt_q    <= '0;
              rd_en_q     <= 1'b1;
              rd_addr_q   <= '0;
            end
          end
        end
        ST_RUN: begin
          if (issue_cnt_q == num_ch_q) begin
            state_q <= ST_DRAIN;
          end else if (credit_ok) begin
            rd_en_q     <= 1'b1;
            rd_addr_q   <= issue_cnt_q[ADDR_WIDTH-1:0];
            issue_cnt_q <= issue_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_wr) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  se_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (hs_accept),
    .push_data_i (bus.hs_out),
    .pop_i       (wr_fire),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.hs_en   = hs_en_q;
  assign bus.hs_data = hs_en_q ? bus.rd_data : '0;
  assign bus.wr_en   = !fifo_empty;
  assign bus.wr_addr = wr_cnt_q[ADDR_WIDTH-1:0];
  assign bus.wr_data = fifo_empty ? '0 : fifo_head;
endmodule
